imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed little-endian program from a byte source into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the load is accepted.
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]      len_lo_reg;
    logic [15:0]     len_reg;
    logic [ADDR_W:0] word_cnt_reg;
    logic [1:0]      byte_cnt_reg;
    logic [31:0]     word_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      csum_reg;
`endif

    logic rx_ready_reg, rx_ready_next;
    logic mem_we_reg, mem_we_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;
    logic error_reg, error_next;
    logic core_hold_reg, core_hold_next;

    logic            accept;
    logic            restart;
    logic            len_bad;
    logic            more_words;
    logic [15:0]     len_next;
    logic [ADDR_W:0] word_inc;

    assign accept     = rx_valid && rx_ready_reg;
    assign restart    = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
    assign len_next   = {rx_data, len_lo_reg};
    assign len_bad    = (len_next == 16'd0) || (32'(len_next) > DEPTH);
    assign word_inc   = word_cnt_reg + 1'b1;
    assign more_words = 32'(word_inc) < 32'(len_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: if (restart) state_next = LEN_LO;
            LEN_LO:          if (accept) state_next = LEN_HI;
            LEN_HI:          if (accept) state_next = len_bad ? ERR : DATA;
            DATA:            if (accept && byte_cnt_reg == 2'd3) state_next = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            WRITE:           state_next = more_words ? DATA : CSUM;
            CSUM:            if (accept) state_next = (rx_data == csum_reg) ? DONE : ERR;
`else
            WRITE:           state_next = more_words ? DATA : DONE;
`endif
            default:         state_next = IDLE;
        endcase
    end

    // Status flags are decoded from the upcoming state and registered, so they are glitch-free
    // and have no combinational path from the byte handshake.
    always_comb begin
        rx_ready_next  = 1'b0;
        mem_we_next    = 1'b0;
        busy_next      = 1'b1;
        done_next      = 1'b0;
        error_next     = 1'b0;
        core_hold_next = 1'b1;
        case (state_next)
            IDLE:                 busy_next = 1'b0;
            LEN_LO, LEN_HI, DATA: rx_ready_next = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:                 rx_ready_next = 1'b1;
`endif
            WRITE:                mem_we_next = 1'b1;
            DONE: begin
                busy_next      = 1'b0;
                done_next      = 1'b1;
                core_hold_next = 1'b0;
            end
            ERR: begin
                busy_next  = 1'b0;
                error_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            rx_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            core_hold_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            rx_ready_reg  <= rx_ready_next;
            mem_we_reg    <= mem_we_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            core_hold_reg <= core_hold_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo_reg   <= '0;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            byte_cnt_reg <= '0;
            word_reg     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            if (restart) begin
                word_cnt_reg <= '0;
                byte_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_reg     <= '0;
`endif
            end
            if (state_reg == LEN_LO && accept) len_lo_reg <= rx_data;
            if (state_reg == LEN_HI && accept) len_reg <= len_next;
            // Shifting in from the top leaves the first byte of each word in bits [7:0].
            if (state_reg == DATA && accept) begin
                word_reg     <= {rx_data, word_reg[31:8]};
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_reg     <= csum_reg ^ rx_data;
`endif
            end
            if (state_reg == WRITE) word_cnt_reg <= word_inc;
        end
    end

    assign rx_ready  = rx_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = word_cnt_reg[ADDR_W-1:0];
    assign mem_wdata = word_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;
    assign core_hold = core_hold_reg;
endmodule
